// File: rtl/seq_bin2bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
package seq_bin2bcd_pkg;

   localparam int DIGIT_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OP   = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Number of decimal digits needed to hold 2^bin_w - 1.
   function automatic int min_digits(input int bin_w);
      longint unsigned v;
      int              d;
      v = (bin_w >= 64) ? '1 : ((64'd1 << bin_w) - 64'd1);
      d = 1;
      while (v >= 64'd10) begin
         v = v / 64'd10;
         d++;
      end
      return d;
   endfunction

endpackage

// File: rtl/seq_bin2bcd_if.sv
// start/ready handshake plus result bus between the converter and its neighbours.
interface seq_bin2bcd_if
   import seq_bin2bcd_pkg::*;
#(
   parameter int BIN_W  = 14,
   parameter int DIGITS = 5
);
   logic                        start;
   logic [BIN_W-1:0]            bin;
   logic                        ready;
   logic                        done_tick;
   logic [DIGIT_W*DIGITS-1:0]   bcd;

   modport master (output start, bin, input ready, done_tick, bcd);
   modport slave  (input start, bin, output ready, done_tick, bcd);
endinterface

// File: rtl/seq_bin2bcd_bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
// Codes 10..15 wrap modulo 16 so the result is always defined.
module bcd_digit_adj
   import seq_bin2bcd_pkg::*;
(
   input  logic [DIGIT_W-1:0] din,
   output logic [DIGIT_W-1:0] dout
);

   assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/seq_bin2bcd.sv
// Sequential binary-to-BCD converter, one shift-and-add-3 step per clock.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   ST_IDLE | ready=1, waiting for start; bcd holds the last result
//   ST_OP   | one adjust+shift per edge, BIN_W edges in total
//   ST_DONE | done_tick=1 for one cycle, bcd holds the final result
module seq_bin2bcd
   import seq_bin2bcd_pkg::*;
#(
   parameter int BIN_W  = 14,
   parameter int DIGITS = 5
)(
   input  logic           clk,
   input  logic           reset,
   seq_bin2bcd_if.slave   bus
);

   localparam int BCD_W = DIGIT_W * DIGITS;
   localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
   localparam int CAT_W = BCD_W + BIN_W;

   generate
      if (DIGITS < min_digits(BIN_W)) begin : g_digits_chk
         $error("seq_bin2bcd: DIGITS=%0d too small for BIN_W=%0d", DIGITS, BIN_W);
      end
   endgenerate

   state_t             state;
   logic [BIN_W-1:0]   bin_q;
   logic [BCD_W-1:0]   bcd_q;
   logic [CNT_W-1:0]   cnt;
   logic               ready_q;
   logic               done_q;

   logic [BCD_W-1:0]   adj;
   logic [CAT_W-1:0]   shifted;

   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adj u_adj (
         .din  (bcd_q[g*DIGIT_W +: DIGIT_W]),
         .dout (adj[g*DIGIT_W +: DIGIT_W])
      );
   end

   // Binary MSB falls into the LSB of digit 0.
   assign shifted = {adj, bin_q} << 1;

   // Sequencer: capture on accept, BIN_W adjust/shift steps, one DONE cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= ST_IDLE;
         bin_q   <= '0;
         bcd_q   <= '0;
         cnt     <= '0;
         ready_q <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.start) begin
                  bin_q   <= bus.bin;
                  bcd_q   <= '0;
                  cnt     <= CNT_W'(BIN_W - 1);
                  ready_q <= 1'b0;
                  state   <= ST_OP;
               end
            end
            ST_OP: begin
               bcd_q <= shifted[CAT_W-1:BIN_W];
               bin_q <= shifted[BIN_W-1:0];
               if (cnt == '0) begin
                  done_q <= 1'b1;
                  state  <= ST_DONE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_DONE: begin
               done_q  <= 1'b0;
               ready_q <= 1'b1;
               state   <= ST_IDLE;
            end
            default: begin
               done_q  <= 1'b0;
               ready_q <= 1'b1;
               state   <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.ready     = ready_q;
   assign bus.done_tick = done_q;
   assign bus.bcd       = bcd_q;

endmodule
